// File: rtl/sys_pkg.sv
// Shared definitions for the system controller: FSM states, width helpers and LED bit map.
package sys_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_CFG,
        S_RUN,
        S_FLUSH
    } sys_state_t;

    localparam int LED_RUN     = 0;
    localparam int LED_BUSY    = 1;
    localparam int LED_TIMEOUT = 2;
    localparam int LED_FLUSH   = 3;

    // A single mode still needs a one-bit bus so the port never collapses to zero width.
    function automatic int mode_width(input int num_modes);
        return (num_modes > 1) ? $clog2(num_modes) : 1;
    endfunction

    function automatic int count_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability counter for one asynchronous board input.
module sync_debounce
    import sys_pkg::*;
#(
    parameter int DB_COUNT = 2500000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_raw,
    output logic o_db
);

    localparam int CW = count_width(DB_COUNT);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= i_raw;
            sync_2 <= sync_1;
        end
    end

    // Any cycle that agrees with the accepted value restarts the stability count.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stable_cnt <= '0;
            o_db       <= 1'b0;
        end else if (sync_2 == o_db) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DB_COUNT - 1)) begin
            stable_cnt <= '0;
            o_db       <= sync_2;
        end else begin
            stable_cnt <= stable_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sys_control_n.sv
// System controller: boot-time camera configuration with timeout and retry, debounced mode and
// filter controls, and frame-aligned application of changes followed by a pipeline flush.
module sys_control_n
    import sys_pkg::*;
#(
    parameter  int NUM_MODES    = 2,
    parameter  int FILT_W       = 1,
    parameter  int DB_COUNT     = 2500000,
    parameter  int BOOT_DELAY   = 1250000,
    parameter  int CFG_TIMEOUT  = 12500000,
    parameter  int CFG_RETRIES  = 3,
    parameter  int FLUSH_CYCLES = 16,
    localparam int MODE_W       = mode_width(NUM_MODES)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_sof,
    input  logic              i_cfg_done,
    input  logic              i_btn_mode,
    input  logic [FILT_W-1:0] i_sw_filter,
    output logic              o_cfg_start,
    output logic [MODE_W-1:0] o_mode,
    output logic [FILT_W-1:0] o_filter_enable,
    output logic              o_pipe_flush,
    output logic              o_cfg_timeout,
    output logic [3:0]        o_status_leds
);

    localparam int T_LIMIT = (BOOT_DELAY > CFG_TIMEOUT)
                           ? ((BOOT_DELAY > FLUSH_CYCLES) ? BOOT_DELAY : FLUSH_CYCLES)
                           : ((CFG_TIMEOUT > FLUSH_CYCLES) ? CFG_TIMEOUT : FLUSH_CYCLES);
    localparam int TW = count_width(T_LIMIT);
    localparam int AW = count_width(CFG_RETRIES + 1);

    sys_state_t        state;
    sys_state_t        state_nx;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nx;
    logic [AW-1:0]     attempt;
    logic [AW-1:0]     attempt_nx;
    logic              cfg_start_nx;
    logic              timeout_nx;
    logic              flush_nx;
    logic [MODE_W-1:0] mode_nx;
    logic [FILT_W-1:0] filter_nx;
    logic [3:0]        leds_nx;

    logic              btn_db;
    logic              btn_db_q;
    logic [FILT_W-1:0] filt_db;
    logic [MODE_W-1:0] pending_mode;
    logic [FILT_W-1:0] pending_filter;

    sync_debounce #(.DB_COUNT(DB_COUNT)) u_btn_db (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_raw  (i_btn_mode),
        .o_db   (btn_db)
    );

    for (genvar g = 0; g < FILT_W; g++) begin : g_filt_db
        sync_debounce #(.DB_COUNT(DB_COUNT)) u_filt_db (
            .i_clk  (i_clk),
            .i_rstn (i_rstn),
            .i_raw  (i_sw_filter[g]),
            .o_db   (filt_db[g])
        );
    end

    assign pending_filter = filt_db;

    // Presses accumulate here until a frame boundary in S_RUN picks them up.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            btn_db_q     <= 1'b0;
            pending_mode <= '0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_db && !btn_db_q) begin
                pending_mode <= (pending_mode == MODE_W'(NUM_MODES - 1))
                              ? '0 : pending_mode + MODE_W'(1);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        attempt_nx   = attempt;
        cfg_start_nx = 1'b0;
        timeout_nx   = o_cfg_timeout;
        flush_nx     = o_pipe_flush;
        mode_nx      = o_mode;
        filter_nx    = o_filter_enable;
        unique case (state)
            S_BOOT: begin
                if (timer == TW'(BOOT_DELAY - 1)) begin
                    state_nx     = S_CFG;
                    timer_nx     = '0;
                    attempt_nx   = AW'(1);
                    cfg_start_nx = 1'b1;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            // A done arriving on the timeout cycle takes priority and leaves the flag alone.
            S_CFG: begin
                if (i_cfg_done) begin
                    state_nx = S_RUN;
                    timer_nx = '0;
                end else if (timer == TW'(CFG_TIMEOUT - 1)) begin
                    timeout_nx = 1'b1;
                    timer_nx   = '0;
                    if (attempt < AW'(CFG_RETRIES)) begin
                        cfg_start_nx = 1'b1;
                        attempt_nx   = attempt + AW'(1);
                    end else begin
                        state_nx = S_RUN;
                    end
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            S_RUN: begin
                if (i_sof && ((pending_mode != o_mode) || (pending_filter != o_filter_enable))) begin
                    mode_nx   = pending_mode;
                    filter_nx = pending_filter;
                    flush_nx  = 1'b1;
                    timer_nx  = '0;
                    state_nx  = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (timer == TW'(FLUSH_CYCLES - 1)) begin
                    flush_nx = 1'b0;
                    timer_nx = '0;
                    state_nx = S_RUN;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            default: state_nx = S_BOOT;
        endcase
        leds_nx              = '0;
        leds_nx[LED_RUN]     = (state_nx == S_RUN);
        leds_nx[LED_BUSY]    = (state_nx == S_CFG);
        leds_nx[LED_TIMEOUT] = timeout_nx;
        leds_nx[LED_FLUSH]   = flush_nx;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state           <= S_BOOT;
            timer           <= '0;
            attempt         <= '0;
            o_cfg_start     <= 1'b0;
            o_mode          <= '0;
            o_filter_enable <= '0;
            o_pipe_flush    <= 1'b0;
            o_cfg_timeout   <= 1'b0;
            o_status_leds   <= '0;
        end else begin
            state           <= state_nx;
            timer           <= timer_nx;
            attempt         <= attempt_nx;
            o_cfg_start     <= cfg_start_nx;
            o_mode          <= mode_nx;
            o_filter_enable <= filter_nx;
            o_pipe_flush    <= flush_nx;
            o_cfg_timeout   <= timeout_nx;
            o_status_leds   <= leds_nx;
        end
    end

endmodule

// File: tb/tb_sys_control_n.sv
// Bench for sys_control_n: directed vector table, hand-built corner sequences and randomized
// traffic, every cycle compared against a frame-level reference model.
module tb_sys_control_n;

    localparam int NUM_MODES    = 3;
    localparam int FILT_W       = 2;
    localparam int DB_COUNT     = 4;
    localparam int BOOT_DELAY   = 10;
    localparam int CFG_TIMEOUT  = 20;
    localparam int CFG_RETRIES  = 2;
    localparam int FLUSH_CYCLES = 8;
    localparam int MODE_W       = 2;

    localparam int P_BOOT  = 0;
    localparam int P_CFG   = 1;
    localparam int P_RUN   = 2;
    localparam int P_FLUSH = 3;

    logic              i_clk;
    logic              i_rstn;
    logic              i_sof;
    logic              i_cfg_done;
    logic              i_btn_mode;
    logic [FILT_W-1:0] i_sw_filter;
    logic              o_cfg_start;
    logic [MODE_W-1:0] o_mode;
    logic [FILT_W-1:0] o_filter_enable;
    logic              o_pipe_flush;
    logic              o_cfg_timeout;
    logic [3:0]        o_status_leds;

    int checks = 0;
    int errors = 0;

    bit              b_done;
    bit              b_btn;
    bit [FILT_W-1:0] b_sw;
    string           scen;

    int              k;
    int              m_phase;
    int              m_deadline;
    int              m_attempt;
    int              m_presses;
    int              m_mode;
    bit              m_start;
    bit              m_timeout;
    bit              m_flush;
    bit              m_credit;
    bit [FILT_W-1:0] m_filt;
    bit [FILT_W:0]   m_db;
    bit [FILT_W:0]   hist[$];

    typedef struct {
        string           name;
        bit [FILT_W-1:0] sw;
        int              btn_hi;
        bit              sof;
        int              exp_mode;
        bit [FILT_W-1:0] exp_filt;
        bit              exp_flush;
    } vec_t;

    vec_t vecs[10];

    sys_control_n #(
        .NUM_MODES    (NUM_MODES),
        .FILT_W       (FILT_W),
        .DB_COUNT     (DB_COUNT),
        .BOOT_DELAY   (BOOT_DELAY),
        .CFG_TIMEOUT  (CFG_TIMEOUT),
        .CFG_RETRIES  (CFG_RETRIES),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .i_sof           (i_sof),
        .i_cfg_done      (i_cfg_done),
        .i_btn_mode      (i_btn_mode),
        .i_sw_filter     (i_sw_filter),
        .o_cfg_start     (o_cfg_start),
        .o_mode          (o_mode),
        .o_filter_enable (o_filter_enable),
        .o_pipe_flush    (o_pipe_flush),
        .o_cfg_timeout   (o_cfg_timeout),
        .o_status_leds   (o_status_leds)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // The DUT sees a raw sample two edges late; missing history counts as the reset value.
    function automatic bit synced_sample(input int idx, input int b);
        if (idx < 0) return 1'b0;
        return hist[idx][b];
    endfunction

    function automatic void model_reset();
        k          = 0;
        m_phase    = P_BOOT;
        m_deadline = 0;
        m_attempt  = 0;
        m_presses  = 0;
        m_mode     = 0;
        m_start    = 1'b0;
        m_timeout  = 1'b0;
        m_flush    = 1'b0;
        m_credit   = 1'b0;
        m_filt     = '0;
        m_db       = '0;
        hist.delete();
    endfunction

    // Event times are absolute edge numbers since reset release rather than running counters.
    function automatic void model_edge(input bit sof, input bit done, input bit [FILT_W:0] raw);
        int n;
        int pend;
        bit all_differ;
        k++;
        m_start = 1'b0;
        pend    = m_presses % NUM_MODES;
        case (m_phase)
            P_BOOT: begin
                if (k == BOOT_DELAY) begin
                    m_start    = 1'b1;
                    m_attempt  = 1;
                    m_deadline = k + CFG_TIMEOUT;
                    m_phase    = P_CFG;
                end
            end
            P_CFG: begin
                if (done) begin
                    m_phase = P_RUN;
                end else if (k == m_deadline) begin
                    m_timeout = 1'b1;
                    if (m_attempt < CFG_RETRIES) begin
                        m_start    = 1'b1;
                        m_attempt  = m_attempt + 1;
                        m_deadline = k + CFG_TIMEOUT;
                    end else begin
                        m_phase = P_RUN;
                    end
                end
            end
            P_RUN: begin
                if (sof && (pend != m_mode || m_db[FILT_W:1] != m_filt)) begin
                    m_mode     = pend;
                    m_filt     = m_db[FILT_W:1];
                    m_flush    = 1'b1;
                    m_deadline = k + FLUSH_CYCLES;
                    m_phase    = P_FLUSH;
                end
            end
            default: begin
                if (k == m_deadline) begin
                    m_flush = 1'b0;
                    m_phase = P_RUN;
                end
            end
        endcase
        m_presses = m_presses + int'(m_credit);
        m_credit  = 1'b0;
        hist.push_back(raw);
        n = hist.size();
        for (int b = 0; b <= FILT_W; b++) begin
            all_differ = 1'b1;
            for (int j = 0; j < DB_COUNT; j++) begin
                if (synced_sample(n - 3 - j, b) == m_db[b]) all_differ = 1'b0;
            end
            if (all_differ) begin
                m_db[b] = ~m_db[b];
                if (b == 0 && m_db[b]) m_credit = 1'b1;
            end
        end
    endfunction

    task automatic checkOutput(input string name);
        logic [10:0] got;
        logic [10:0] want;
        got  = {o_cfg_start, o_mode, o_filter_enable, o_pipe_flush, o_cfg_timeout, o_status_leds};
        want = {m_start, MODE_W'(m_mode), m_filt, m_flush, m_timeout,
                m_flush, m_timeout, (m_phase == P_CFG), (m_phase == P_RUN)};
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s edge %0d: got {start,mode,filt,flush,tout,leds}=%b, want %b",
                     name, k, got, want);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sof);
        i_sof       = sof;
        i_cfg_done  = b_done;
        i_btn_mode  = b_btn;
        i_sw_filter = b_sw;
        @(posedge i_clk);
        model_edge(sof, b_done, {b_sw, b_btn});
        #1;
        checkOutput(scen);
    endtask

    // Asserts reset mid-cycle so the clear must be asynchronous, then releases after two edges.
    task automatic doReset();
        #2;
        i_rstn = 1'b0;
        #1;
        checkValue("reset_outputs_async",
                   32'({o_cfg_start, o_mode, o_filter_enable, o_pipe_flush, o_cfg_timeout, o_status_leds}),
                   32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int starts;
        int first_start;
        int second_start;
        int run_edge;
        int flush_len;
        int done_at;
        int btn_left;

        vecs[0] = '{"press_1_no_sof",   2'b00, 6, 1'b0, 0, 2'b00, 1'b0};
        vecs[1] = '{"press_2_no_sof",   2'b00, 6, 1'b0, 0, 2'b00, 1'b0};
        vecs[2] = '{"press_3_no_sof",   2'b00, 6, 1'b0, 0, 2'b00, 1'b0};
        vecs[3] = '{"press_4_no_sof",   2'b00, 6, 1'b0, 0, 2'b00, 1'b0};
        vecs[4] = '{"sof_applies_wrap", 2'b00, 0, 1'b1, 1, 2'b00, 1'b1};
        vecs[5] = '{"glitch_3_ignored", 2'b00, 3, 1'b1, 1, 2'b00, 1'b0};
        vecs[6] = '{"press_6_applied",  2'b00, 6, 1'b1, 2, 2'b00, 1'b1};
        vecs[7] = '{"filter_10",        2'b10, 0, 1'b1, 2, 2'b10, 1'b1};
        vecs[8] = '{"press_wrap_to_0",  2'b10, 6, 1'b1, 0, 2'b10, 1'b1};
        vecs[9] = '{"filter_01_press",  2'b01, 6, 1'b1, 1, 2'b01, 1'b1};

        i_rstn      = 1'b0;
        i_sof       = 1'b0;
        i_cfg_done  = 1'b0;
        i_btn_mode  = 1'b0;
        i_sw_filter = '0;
        b_done      = 1'b0;
        b_btn       = 1'b0;
        b_sw        = '0;
        model_reset();
        @(posedge i_clk);
        #1;

        // Boot with no camera answer: two attempts, both time out, then run unconfigured.
        scen = "boot_timeout";
        doReset();
        starts = 0;
        first_start = -1;
        second_start = -1;
        run_edge = -1;
        for (int c = 1; c <= 60; c++) begin
            b_btn = (c >= 15 && c < 22);
            applyStimulus(c == 40);
            if (o_cfg_start === 1'b1) begin
                starts++;
                if (starts == 1) first_start = c;
                if (starts == 2) second_start = c;
            end
            if (o_status_leds[0] === 1'b1 && run_edge < 0) run_edge = c;
        end
        checkValue("boot_start_count", 32'(starts), 32'd2);
        checkValue("boot_first_start_edge", 32'(first_start), 32'd10);
        checkValue("boot_retry_start_edge", 32'(second_start), 32'd30);
        checkValue("boot_timeout_flag", 32'(o_cfg_timeout), 32'd1);
        checkValue("boot_run_edge", 32'(run_edge), 32'd50);
        applyStimulus(1'b1);
        checkValue("boot_pending_mode_applied", 32'(o_mode), 32'd1);
        checkValue("boot_pending_flush", 32'(o_pipe_flush), 32'd1);
        repeat (10) applyStimulus(1'b0);

        // Camera answers five cycles after the first start pulse.
        scen = "cfg_success";
        doReset();
        starts = 0;
        for (int c = 1; c <= 45; c++) begin
            b_done = (c >= 15);
            applyStimulus(1'b0);
            if (o_cfg_start === 1'b1) starts++;
        end
        checkValue("cfg_ok_start_count", 32'(starts), 32'd1);
        checkValue("cfg_ok_timeout_flag", 32'(o_cfg_timeout), 32'd0);
        checkValue("cfg_ok_run_led", 32'(o_status_leds), 32'b0001);

        // Done arriving on the exact timeout cycle beats the timeout.
        scen = "cfg_done_vs_timeout";
        b_done = 1'b0;
        doReset();
        starts = 0;
        for (int c = 1; c <= 45; c++) begin
            b_done = (c >= 30);
            applyStimulus(1'b0);
            if (o_cfg_start === 1'b1) starts++;
        end
        checkValue("done_wins_start_count", 32'(starts), 32'd1);
        checkValue("done_wins_timeout_flag", 32'(o_cfg_timeout), 32'd0);

        for (int v = 0; v < 10; v++) begin
            scen = vecs[v].name;
            b_sw = vecs[v].sw;
            if (vecs[v].btn_hi > 0) begin
                b_btn = 1'b1;
                repeat (vecs[v].btn_hi) applyStimulus(1'b0);
                b_btn = 1'b0;
            end
            repeat (8) applyStimulus(1'b0);
            if (vecs[v].sof) applyStimulus(1'b1);
            checkValue({vecs[v].name, "_mode"}, 32'(o_mode), 32'(vecs[v].exp_mode));
            checkValue({vecs[v].name, "_filter"}, 32'(o_filter_enable), 32'(vecs[v].exp_filt));
            checkValue({vecs[v].name, "_flush"}, 32'(o_pipe_flush), 32'(vecs[v].exp_flush));
            repeat (10) applyStimulus(1'b0);
        end

        // Filter change, then a press and a frame during the flush that must be deferred.
        scen = "sof_during_flush";
        b_sw = 2'b10;
        repeat (8) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkValue("flush_filter_applied", 32'(o_filter_enable), 32'b10);
        flush_len = int'(o_pipe_flush);
        for (int c = 1; c <= 30; c++) begin
            b_btn = (c <= 6);
            applyStimulus(c == 8);
            if (o_pipe_flush === 1'b1) flush_len++;
        end
        checkValue("flush_length_first", 32'(flush_len), 32'(FLUSH_CYCLES));
        checkValue("flush_sof_ignored_mode", 32'(o_mode), 32'd1);
        applyStimulus(1'b1);
        checkValue("deferred_press_mode", 32'(o_mode), 32'd2);
        flush_len = int'(o_pipe_flush);
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(1'b0);
            if (o_pipe_flush === 1'b1) flush_len++;
        end
        checkValue("flush_length_second", 32'(flush_len), 32'(FLUSH_CYCLES));

        // Reset in the third flush cycle, then the boot sequence must start over.
        scen = "reset_mid_flush";
        b_sw = 2'b00;
        repeat (8) applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkValue("pre_reset_flush_active", 32'(o_pipe_flush), 32'd1);
        b_done = 1'b0;
        doReset();
        first_start = -1;
        for (int c = 1; c <= 14; c++) begin
            b_done = (c >= 13);
            applyStimulus(1'b0);
            if (o_cfg_start === 1'b1 && first_start < 0) first_start = c;
        end
        checkValue("reboot_first_start_edge", 32'(first_start), 32'd10);
        checkValue("reboot_mode_cleared", 32'(o_mode), 32'd0);

        // Randomized traffic across several boots with random camera answer times.
        for (int r = 0; r < 3; r++) begin
            scen = "random";
            b_done = 1'b0;
            b_btn = 1'b0;
            doReset();
            done_at = int'($urandom_range(5, 60));
            btn_left = 0;
            for (int c = 1; c <= 400; c++) begin
                if (c == done_at) b_done = 1'b1;
                if (btn_left == 0) begin
                    b_btn = ~b_btn;
                    btn_left = int'($urandom_range(1, 9));
                end else begin
                    btn_left--;
                end
                if ($urandom_range(0, 40) == 0) b_sw = FILT_W'($urandom_range(0, 3));
                applyStimulus($urandom_range(0, 9) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_control_n.md
Name: sys_control_n

Overview:
Parametrised successor to the system controller that sits between the board controls and the camera, memory and display blocks, in the i_sysclk domain. Sequences camera configuration after reset, with a timeout and bounded retry. Debounces the mode button and filter switches. Applies mode and filter changes only at a frame boundary (i_sof), and on each applied change asserts a pipeline flush of fixed length. Generalises the single colour/greyscale mode and the single gaussian switch to NUM_MODES modes and FILT_W filter enables.

Parameters:
NUM_MODES, 2, number of display/processing modes; o_mode wraps at NUM_MODES-1
FILT_W, 1, number of independent filter-enable switches
DB_COUNT, 2500000, cycles a synchronised input must be stable before it is accepted (20 ms at 125 MHz)
BOOT_DELAY, 1250000, cycles from reset release to the first o_cfg_start
CFG_TIMEOUT, 12500000, cycles to wait for i_cfg_done per attempt
CFG_RETRIES, 3, maximum config attempts before running unconfigured
FLUSH_CYCLES, 16, o_pipe_flush pulse length in cycles

Ports:
i_clk  in  1  system clock (125 MHz)
i_rstn  in  1  asynchronous active-low reset
i_sof  in  1  start-of-frame, single-cycle pulse, already in the i_clk domain
i_cfg_done  in  1  camera config complete (level)
i_btn_mode  in  1  raw mode button, asynchronous, active-high
i_sw_filter  in  FILT_W  raw filter switches, asynchronous
o_cfg_start  out  1  single-cycle config start pulse
o_mode  out  MODE_W  active mode; MODE_W = max(1, clog2(NUM_MODES))
o_filter_enable  out  FILT_W  active filter enables
o_pipe_flush  out  1  pipeline flush
o_cfg_timeout  out  1  sticky flag: at least one config attempt timed out
o_status_leds  out  4  {flush, cfg_timeout, cfg_busy, run}

Behaviour:
- Reset (asynchronous, active-low). All outputs go to 0. FSM enters S_BOOT. Counters, debounced values, pending mode and pending filters clear to 0.
- Input conditioning. Each bit of i_btn_mode and i_sw_filter passes through a 2-FF synchroniser, then an independent debounce counter. The debounced value updates only after DB_COUNT consecutive cycles that differ from the current debounced value. Any glitch restarts that bit's counter.
- Button handling. Each debounced rising edge of the button sets pending_mode = (pending_mode == NUM_MODES-1) ? 0 : pending_mode+1. Presses accumulate between frames. pending_filter always tracks the debounced switches.
- FSM:
  - S_BOOT: count BOOT_DELAY cycles, then o_cfg_start=1 for 1 cycle, attempt=1, go to S_CFG.
  - S_CFG: cfg_busy=1. If i_cfg_done=1, go to S_RUN. If the timeout counter reaches CFG_TIMEOUT-1, set o_cfg_timeout=1. Then, if attempt < CFG_RETRIES, pulse o_cfg_start on the next cycle, increment attempt and clear the counter; otherwise go to S_RUN.
  - S_RUN: run=1. On i_sof with (pending_mode != o_mode) or (pending_filter != o_filter_enable):
    - load o_mode <= pending_mode and o_filter_enable <= pending_filter on that edge;
    - assert o_pipe_flush starting the next cycle;
    - go to S_FLUSH.
    - i_sof with no change: no action.
  - S_FLUSH: o_pipe_flush=1 for exactly FLUSH_CYCLES cycles, then S_RUN.
- Ignored events:
  - i_sof outside S_RUN is ignored; pending state is kept and applied at the first i_sof in S_RUN.
  - A button edge on the same cycle as an applying i_sof is not lost: the increment lands in pending_mode and is applied at a later frame.
- i_cfg_done on the same cycle as a timeout: done wins; go to S_RUN, o_cfg_timeout unchanged.
- o_cfg_timeout is cleared only by reset.
- Outputs are registered, with zero combinational paths from inputs to outputs.
- Width rules: counters are sized with clog2 of their limits. pending_mode wraparound uses an explicit compare, not a power-of-2 mask, so non-power-of-2 NUM_MODES is correct.

Decomposition:
- Shared package sys_pkg: FSM state enum (S_BOOT, S_CFG, S_RUN, S_FLUSH), the MODE_W function, and LED bit index constants.
- Sub-module sync_debounce (parameter DB_COUNT, 1-bit, synchroniser plus counter), instantiated FILT_W+1 times.

Test Plan:
Parameters for all scenarios: NUM_MODES=3, FILT_W=2, DB_COUNT=4, BOOT_DELAY=10, CFG_TIMEOUT=20, CFG_RETRIES=2, FLUSH_CYCLES=8.
- Boot: release reset, hold i_cfg_done=0 -> o_cfg_start pulse at cycle 10 after release; second pulse 20 cycles later with o_cfg_timeout=1; S_RUN (led[0]=1) after the second timeout.
- Config success: raise i_cfg_done 5 cycles after the first o_cfg_start -> S_RUN, o_cfg_timeout=0, no further o_cfg_start.
- Button wrap and frame alignment: 4 clean presses before any i_sof -> o_mode stays 0; at the next i_sof o_mode=1 ((0+4) mod 3) and o_pipe_flush is high exactly 8 cycles.
- Debounce: a 3-cycle button glitch -> no mode change at i_sof and no flush; a 6-cycle press -> change applied.
- Filter plus SOF during flush: set i_sw_filter=2'b10, then i_sof -> o_filter_enable=2'b10 plus flush; press the button and pulse i_sof during the flush -> ignored; next i_sof -> o_mode increments and a new 8-cycle flush.
- Reset mid-flush: assert i_rstn=0 in flush cycle 3 -> all outputs 0 immediately (asynchronous); after release the sequence restarts from S_BOOT.
